// File: rtl/vm_customer_driver.sv
// rtl/vm_customer_driver.sv - customer-side initiator: pays in greedy coins, presses the button, checks the result
// Optional `VM_CUST_STATS_EN adds wrapping stat_txn_o/stat_mismatch_o/stat_revenue_o counters.
module vm_customer_driver #(
  parameter int unsigned WATER_PRICE = 5,
  parameter int unsigned SODA_PRICE  = 15,
  parameter int unsigned COIN_GAP    = 1,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CHANGE_IDLE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_bev_i,
  input  logic [7:0]  cmd_amount_i,
  output logic [2:0]  coin_in_o,
  output logic [1:0]  button_in_o,
  input  logic [1:0]  change_out_i,
  input  logic [1:0]  beverage_out_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_bev_o,
  output logic [8:0]  rsp_change_o,
  output logic [3:0]  rsp_coins_o,
  output logic        rsp_timeout_o,
  output logic        rsp_mismatch_o
`ifdef VM_CUST_STATS_EN
  ,
  output logic [15:0] stat_txn_o,
  output logic [15:0] stat_mismatch_o,
  output logic [19:0] stat_revenue_o
`endif
);

  typedef enum logic [2:0] {IDLE, COIN, GAP, BUTTON, WAIT_BEV, COLLECT, REPORT} state_e;

  state_e      state_q, adv_state;
  logic [1:0]  bev_q, rsp_bev_q, button_q, adv_bev;
  logic [7:0]  amount_q, remain_q, remain_d, coin_src, coin_val, price;
  logic [2:0]  coin_q, coin_d;
  logic [3:0]  coins_q;
  logic [8:0]  sum_q, sum_d;
  logic [9:0]  sum_wide;
  logic [31:0] cnt_q, idle_q;
  logic        rsp_valid_q, timeout_q, mismatch_q, mismatch_d, paid;

  function automatic logic [7:0] price_of(input logic [1:0] bev);
    case (bev)
      2'd1:    price_of = 8'(WATER_PRICE);
      2'd2:    price_of = 8'(SODA_PRICE);
      default: price_of = 8'd0;
    endcase
  endfunction

  // In IDLE the greedy selector looks at the incoming command so the first coin is registered on acceptance.
  assign coin_src = (state_q == IDLE) ? cmd_amount_i : remain_q;
  assign adv_bev  = (state_q == IDLE) ? cmd_bev_i : bev_q;

  always_comb begin
    coin_d   = 3'd0;
    coin_val = 8'd0;
    if (coin_src >= 8'd20) begin
      coin_d = 3'd5; coin_val = 8'd20;
    end else if (coin_src >= 8'd10) begin
      coin_d = 3'd4; coin_val = 8'd10;
    end else if (coin_src >= 8'd5) begin
      coin_d = 3'd3; coin_val = 8'd5;
    end else if (coin_src >= 8'd2) begin
      coin_d = 3'd2; coin_val = 8'd2;
    end else if (coin_src >= 8'd1) begin
      coin_d = 3'd1; coin_val = 8'd1;
    end
  end

  assign remain_d  = coin_src - coin_val;
  assign adv_state = (coin_src != 8'd0) ? COIN : ((adv_bev != 2'd0) ? BUTTON : COLLECT);

  assign sum_wide = {1'b0, sum_q} + {8'd0, change_out_i};
  assign sum_d    = sum_wide[9] ? 9'd511 : sum_wide[8:0];

  // Change is only checked when a real beverage was paid for in full.
  assign price      = price_of(bev_q);
  assign paid       = ((bev_q == 2'd1) || (bev_q == 2'd2)) && (amount_q >= price);
  assign mismatch_d = paid ? ((rsp_bev_q != bev_q) || (sum_d != {1'b0, amount_q - price}))
                           : (rsp_bev_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      bev_q       <= 2'd0;
      amount_q    <= 8'd0;
      remain_q    <= 8'd0;
      coin_q      <= 3'd0;
      button_q    <= 2'd0;
      coins_q     <= 4'd0;
      sum_q       <= 9'd0;
      cnt_q       <= 32'd0;
      idle_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_bev_q   <= 2'd0;
      timeout_q   <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          bev_q      <= cmd_bev_i;
          amount_q   <= cmd_amount_i;
          rsp_bev_q  <= 2'd0;
          sum_q      <= 9'd0;
          timeout_q  <= 1'b0;
          mismatch_q <= 1'b0;
          coins_q    <= {3'd0, adv_state == COIN};
          state_q    <= adv_state;
          coin_q     <= coin_d;
          remain_q   <= remain_d;
          button_q   <= (adv_state == BUTTON) ? adv_bev : 2'd0;
          cnt_q      <= 32'd0;
          idle_q     <= 32'd0;
        end
        COIN: begin
          coin_q  <= 3'd0;
          cnt_q   <= 32'd0;
          state_q <= GAP;
        end
        GAP: if (cnt_q + 32'd1 >= COIN_GAP) begin
          coins_q  <= coins_q + {3'd0, adv_state == COIN};
          state_q  <= adv_state;
          coin_q   <= coin_d;
          remain_q <= remain_d;
          button_q <= (adv_state == BUTTON) ? adv_bev : 2'd0;
          cnt_q    <= 32'd0;
          idle_q   <= 32'd0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        BUTTON: begin
          button_q <= 2'd0;
          cnt_q    <= 32'd0;
          state_q  <= WAIT_BEV;
        end
        WAIT_BEV: begin
          sum_q <= sum_d;
          if (beverage_out_i != 2'd0) begin
            rsp_bev_q <= beverage_out_i;
            state_q   <= COLLECT;
            cnt_q     <= 32'd0;
            idle_q    <= 32'd0;
          end else if (cnt_q + 32'd1 >= TIMEOUT) begin
            timeout_q <= 1'b1;
            state_q   <= COLLECT;
            cnt_q     <= 32'd0;
            idle_q    <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        COLLECT: begin
          sum_q  <= sum_d;
          cnt_q  <= cnt_q + 32'd1;
          idle_q <= (change_out_i != 2'd0) ? 32'd0 : idle_q + 32'd1;
          if (((change_out_i == 2'd0) && (idle_q + 32'd1 >= CHANGE_IDLE)) ||
              (cnt_q + 32'd1 >= TIMEOUT)) begin
            state_q     <= REPORT;
            rsp_valid_q <= 1'b1;
            mismatch_q  <= mismatch_d;
          end
        end
        REPORT: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = rst_i && (state_q == IDLE);
  assign coin_in_o      = coin_q;
  assign button_in_o    = button_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_bev_o      = rsp_bev_q;
  assign rsp_change_o   = sum_q;
  assign rsp_coins_o    = coins_q;
  assign rsp_timeout_o  = timeout_q;
  assign rsp_mismatch_o = mismatch_q;

`ifdef VM_CUST_STATS_EN
  logic [15:0] stat_txn_q, stat_mismatch_q;
  logic [19:0] stat_revenue_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_txn_q      <= 16'd0;
      stat_mismatch_q <= 16'd0;
      stat_revenue_q  <= 20'd0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      stat_txn_q <= stat_txn_q + 16'd1;
      if (mismatch_q)
        stat_mismatch_q <= stat_mismatch_q + 16'd1;
      else if (rsp_bev_q != 2'd0)
        stat_revenue_q <= stat_revenue_q + {12'd0, price_of(rsp_bev_q)};
    end
  end

  assign stat_txn_o      = stat_txn_q;
  assign stat_mismatch_o = stat_mismatch_q;
  assign stat_revenue_o  = stat_revenue_q;
`endif

endmodule

// File: tb/tb_vm_customer_driver.sv
// tb/tb_vm_customer_driver.sv - directed self-checking bench for vm_customer_driver
module tb_vm_customer_driver;

  localparam int WATER = 5;
  localparam int SODA = 15;
  localparam int GAPC = 1;
  localparam int TMO = 64;
  localparam int CIDLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_bev = 2'd0;
  logic [7:0] cmd_amount = 8'd0;
  logic [2:0] coin_in;
  logic [1:0] button_in;
  logic [1:0] change_out = 2'd0, beverage_out = 2'd0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [1:0] rsp_bev;
  logic [8:0] rsp_change;
  logic [3:0] rsp_coins;
  logic rsp_timeout, rsp_mismatch;

  always #5 clk = ~clk;

  vm_customer_driver #(
    .WATER_PRICE(WATER), .SODA_PRICE(SODA), .COIN_GAP(GAPC), .TIMEOUT(TMO), .CHANGE_IDLE(CIDLE)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_bev_i(cmd_bev), .cmd_amount_i(cmd_amount),
    .coin_in_o(coin_in), .button_in_o(button_in),
    .change_out_i(change_out), .beverage_out_i(beverage_out),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_bev_o(rsp_bev), .rsp_change_o(rsp_change), .rsp_coins_o(rsp_coins),
    .rsp_timeout_o(rsp_timeout), .rsp_mismatch_o(rsp_mismatch)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: expected coin/button trace per cycle and the response record.
  typedef struct { int coin; int button; } drv_t;
  drv_t exp_q[$];
  drv_t d;
  bit active = 0;
  bit rsp_armed = 0;
  int cur_bev, cur_amt, m_sum, m_got;
  bit m_given;
  int e_bev, e_change, e_coins, e_timeout, e_mismatch;

  function automatic int price_of(input int bev);
    return (bev == 1) ? WATER : ((bev == 2) ? SODA : 0);
  endfunction

  function automatic int coin_count(input int amt);
    int vals[5] = '{20, 10, 5, 2, 1};
    int r, n, k;
    r = amt; n = 0;
    while (r > 0) begin
      k = 0;
      while (vals[k] > r) k++;
      r -= vals[k];
      n++;
    end
    return n;
  endfunction

  task automatic build_drive(input int bev, input int amt);
    int vals[5] = '{20, 10, 5, 2, 1};
    int r, k;
    drv_t e;
    r = amt;
    while (r > 0) begin
      k = 0;
      while (vals[k] > r) k++;
      e.coin = 5 - k; e.button = 0;
      exp_q.push_back(e);
      r -= vals[k];
      e.coin = 0;
      repeat (GAPC) exp_q.push_back(e);
    end
    if (bev != 0) begin
      e.coin = 0; e.button = bev;
      exp_q.push_back(e);
    end
  endtask

  task automatic arm();
    int p;
    bit paid;
    p = price_of(cur_bev);
    paid = ((cur_bev == 1) || (cur_bev == 2)) && (cur_amt >= p);
    e_bev = m_got;
    e_change = (m_sum > 511) ? 511 : m_sum;
    e_coins = coin_count(cur_amt);
    e_timeout = ((cur_bev != 0) && !m_given) ? 1 : 0;
    e_mismatch = paid ? ((m_got != cur_bev) || (m_sum != cur_amt - p)) : (m_got != 0);
    rsp_armed = 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (active) begin
        check("cmd_ready_busy", cmd_ready, 0);
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          check("coin_in", coin_in, d.coin);
          check("button_in", button_in, d.button);
        end else begin
          check("coin_idle", coin_in, 0);
          check("button_idle", button_in, 0);
        end
      end
      if (!rsp_armed) check("rsp_valid_idle", rsp_valid, 0);
      else if (rsp_valid) begin
        check("rsp_bev", rsp_bev, e_bev);
        check("rsp_change", rsp_change, e_change);
        check("rsp_coins", rsp_coins, e_coins);
        check("rsp_timeout", rsp_timeout, e_timeout);
        check("rsp_mismatch", rsp_mismatch, e_mismatch);
        check("cmd_ready_report", cmd_ready, 0);
      end
    end
  end

  task automatic issue(input int bev, input int amt, output int len);
    int i;
    cur_bev = bev; cur_amt = amt; m_sum = 0; m_got = 0; m_given = 0;
    cmd_bev = bev[1:0]; cmd_amount = amt[7:0]; cmd_valid = 1'b1;
    i = 0;
    while (!cmd_ready && i < 20) begin @(negedge clk); i++; end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    build_drive(bev, amt);
    len = exp_q.size();
    active = 1;
  endtask

  task automatic env_cycle(input int bv, input int ch);
    beverage_out = bv[1:0];
    change_out = ch[1:0];
    m_sum += ch;
    if (bv != 0 && !m_given) begin m_given = 1; m_got = bv; end
    @(negedge clk);
    beverage_out = 2'd0;
    change_out = 2'd0;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    check({name, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    @(posedge clk);
    #1 active = 0; rsp_armed = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, lat;

    check("model_coins_38", coin_count(38), 5);
    check("model_coins_255", coin_count(255), 14);
    check("model_price_soda", price_of(2), 15);

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_coin_in", coin_in, 0);
    check("rst_button_in", button_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_bev, rsp_change, rsp_coins, rsp_timeout, rsp_mismatch}, 0);
    rst = 1'b1;
    #1 check("rel_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    // water, exact payment
    issue(1, 5, len);
    repeat (len) @(negedge clk);
    @(negedge clk);
    env_cycle(0, 0);
    env_cycle(1, 0);
    arm();
    wait_rsp("t1", lat);
    check("t1_bev", rsp_bev, 1);
    check("t1_change", rsp_change, 0);
    check("t1_coins", rsp_coins, 1);
    check("t1_mismatch", rsp_mismatch, 0);
    finish_rsp();

    // soda, 38 paid, refund pulse before the beverage, 23 total change
    issue(2, 38, len);
    check("t2_trace_len", len, 11);
    repeat (len) @(negedge clk);
    @(negedge clk);
    env_cycle(0, 1);
    env_cycle(2, 2);
    repeat (10) env_cycle(0, 2);
    arm();
    wait_rsp("t2", lat);
    check("t2_coins", rsp_coins, 5);
    check("t2_change", rsp_change, 23);
    check("t2_mismatch", rsp_mismatch, 0);
    finish_rsp();

    // water paid but no beverage: timeout is a mismatch
    issue(1, 5, len);
    repeat (len) @(negedge clk);
    arm();
    wait_rsp("t3", lat);
    check("t3_latency", lat, TMO + CIDLE + 1);
    check("t3_timeout", rsp_timeout, 1);
    check("t3_mismatch", rsp_mismatch, 1);
    check("t3_bev", rsp_bev, 0);
    finish_rsp();

    // soda with zero payment: button right away, timeout without mismatch
    issue(2, 0, len);
    repeat (len) @(negedge clk);
    check("t4_button_first", button_in, 2);
    arm();
    wait_rsp("t4", lat);
    check("t4_latency", lat, TMO + CIDLE + 1);
    check("t4_timeout", rsp_timeout, 1);
    check("t4_mismatch", rsp_mismatch, 0);
    check("t4_coins", rsp_coins, 0);
    finish_rsp();

    // coins only, change collected without a button
    issue(0, 7, len);
    repeat (len) @(negedge clk);
    @(negedge clk);
    env_cycle(0, 2);
    env_cycle(0, 1);
    arm();
    wait_rsp("t5", lat);
    check("t5_change", rsp_change, 3);
    check("t5_coins", rsp_coins, 2);
    check("t5_timeout", rsp_timeout, 0);
    finish_rsp();

    // reset during the third coin
    issue(2, 38, len);
    repeat (5) @(negedge clk);
    check("t6_third_coin", coin_in, 3);
    active = 0;
    exp_q.delete();
    #1 rst = 1'b0;
    #1 check("t6_coin_async", coin_in, 0);
    check("t6_rsp_valid_rst", rsp_valid, 0);
    check("t6_cmd_ready_rst", cmd_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_hold_cmd_ready", cmd_ready, 0);
      check("t6_hold_rsp_valid", rsp_valid, 0);
    end
    rst = 1'b1;
    #1 check("t6_cmd_ready_rel", cmd_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("t6_idle_coin", coin_in, 0);
    end

    // response held for 10 cycles, new command raised on the handshake
    rsp_ready = 1'b0;
    issue(1, 5, len);
    repeat (len) @(negedge clk);
    @(negedge clk);
    env_cycle(1, 0);
    arm();
    wait_rsp("t7", lat);
    repeat (10) @(negedge clk);
    check("t7_still_valid", rsp_valid, 1);
    cmd_bev = 2'd3; cmd_amount = 8'd255; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 active = 0; rsp_armed = 0;
    @(negedge clk);
    check("t7_rsp_dropped", rsp_valid, 0);
    check("t7_ready_after", cmd_ready, 1);
    check("t7_not_yet_accepted", coin_in, 0);

    // bev=3 driven as-is with max amount; wrong beverage handed out
    issue(3, 255, len);
    repeat (len) @(negedge clk);
    check("t8_button_raw", button_in, 3);
    @(negedge clk);
    env_cycle(1, 0);
    arm();
    wait_rsp("t8", lat);
    check("t8_coins", rsp_coins, 14);
    check("t8_mismatch", rsp_mismatch, 1);
    check("t8_bev", rsp_bev, 1);
    finish_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
